serial_parity_checker: RTL
==========================

// Module: serial_parity_checker
//
// PURPOSE
// - Receive end of the team's serial parity link: deserialises frames of
//   start bit, DATA_W data bits (LSB first), parity bit and stop bit.
// - Recomputes the parity with an XOR accumulator and checks the received
//   parity and stop bits.
// - Presents the data word with a one-cycle valid pulse and error flags.
// - Sits after the serial link; its output feeds the downstream word consumer.
//
// PARAMETERS
// - DATA_W      3  data bits per frame, >= 2
// - ODD_PARITY  0  0 = even parity (XOR of data and parity = 0); 1 = odd parity (XOR = 1)
//
// PORTS
// - clk         in   1       single clock; all state changes on the rising edge
// - rst         in   1       asynchronous reset, active-high
// - rx_en       in   1       sample strobe; rx_bit is consumed only on edges where rx_en = 1
// - rx_bit      in   1       serial line; idle level 1
// - data_out    out  DATA_W  last received word
// - data_valid  out  1       one-cycle pulse: the frame is complete
// - parity_err  out  1       parity mismatch for the word in data_out
// - frame_err   out  1       stop bit sampled as 0 for the word in data_out
// - busy        out  1       1 whenever state != IDLE
//
// BEHAVIOUR
// - Reset (asynchronous, takes effect immediately):
//   - state = IDLE.
//   - data_out, data_valid, parity_err, frame_err, busy, shift register,
//     bit counter and accumulator all = 0.
// - rx_en = 0: every register holds. The only exception is data_valid, which is 0.
// - IDLE:
//   - enabled sample with rx_bit = 0: this is the start bit. Go to DATA; cnt = 0; acc = 0.
//   - rx_bit = 1: stay in IDLE.
// - DATA, on each enabled sample:
//   - sh = {rx_bit, sh[DATA_W-1:1]}; acc ^= rx_bit; cnt++.
//   - on the sample where cnt == DATA_W-1: go to PARITY.
// - PARITY, on the enabled sample:
//   - perr_q = acc ^ rx_bit ^ ODD_PARITY.
//   - go to STOP.
// - STOP, on the enabled sample:
//   - data_out <= sh; parity_err <= perr_q; frame_err <= ~rx_bit.
//   - data_valid <= 1 for exactly one cycle.
//   - go to IDLE.
// - Latency: data_valid is high in the cycle that follows the clock edge sampling
//   the stop bit. A full frame takes DATA_W+3 enabled samples.
// - data_out, parity_err and frame_err update only together with data_valid.
//   They hold between frames.
// - A bad stop bit still delivers the word, with frame_err = 1. The block
//   returns to IDLE and does not hunt for resynchronisation.
// - Back-to-back frames: the first enabled sample after STOP is evaluated as a
//   start-bit candidate. No gap cycle is required.
// - rst during a frame:
//   - the frame is aborted and no data_valid is produced.
//   - outputs return to their reset values.
// - cnt width is $clog2(DATA_W). The counter never exceeds DATA_W-1.
//
// STRUCTURE
// - Shared package: state encoding constants IDLE=2'd0, DATA=2'd1, PARITY=2'd2,
//   STOP=2'd3. The link bit-level constants (START_LVL=0, STOP_LVL=1) go there
//   too, so the transmit side reuses them.
// - One natural sub-module: parity_accum. It is a 1-bit XOR register with
//   clr / en / din inputs, reusable by the transmitter. The rest (FSM, shift
//   register, counter) stays in this module.
//
// TESTING (DATA_W=3 unless stated; every sample has rx_en=1 unless stated)
// 1. Line 0,1,0,1,0,1:
//    -> data_out=3'b101, data_valid pulses once, parity_err=0, frame_err=0, busy back to 0.
// 2. Line 0,1,0,1,1,1:
//    -> data_out=3'b101, parity_err=1, frame_err=0.
// 3. Line 0,0,1,0,1,0:
//    -> data_out=3'b010, parity_err=0, frame_err=1. The next frame is received normally.
// 4. Frame 0,1,1,1,1,1 with rx_en toggling every cycle:
//    -> data_out=3'b111, no errors.
//    -> data_valid appears only after the 6th enabled sample; no output change on disabled cycles.
// 5. Assert rst after the start bit and 2 data bits:
//    -> all outputs 0 immediately, no data_valid.
//    -> a following frame 0,0,1,0,1,1 gives data_out=3'b010 with no errors.
// 6. All 8 words sent back-to-back with correct parity, at ODD_PARITY=0 and at ODD_PARITY=1:
//    -> 8 data_valid pulses in order, each matching an XOR reference model, zero errors.
//    -> one frame with inverted parity flags parity_err.

Source files
------------

// File: rtl/serial_parity_checker_pkg.sv
// ---------------------------------------------------------------------------
// serial_parity_checker_pkg
//
// Purpose:
//   Shared definitions for both ends of the serial parity link.
//   - Receiver FSM state encoding.
//   - Line-level constants, so the transmitter builds frames from the same
//     values that the receiver checks.
//
// Frame on the wire, one bit per enabled sample:
//   START_LVL, data[0] .. data[DATA_W-1], parity, STOP_LVL
// The line idles at STOP_LVL.
// ---------------------------------------------------------------------------
package serial_parity_checker_pkg;

  // Receiver FSM state. The encoding is fixed so that checkers and waveform
  // viewers can decode the raw 2-bit value.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Line levels of the framing bits. The idle level equals the stop level.
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

endpackage : serial_parity_checker_pkg

// File: rtl/serial_parity_checker_parity_accum.sv
// ---------------------------------------------------------------------------
// parity_accum
//
// Purpose:
//   1-bit running XOR register. The receiver and the transmitter both use it
//   to build frame parity bit by bit.
//
// Ports:
//   clk  in   clock, rising edge
//   rst  in   asynchronous reset, active-high; clears q
//   clr  in   synchronous clear; has priority over en
//   en   in   fold din into the accumulator on this edge
//   din  in   bit to accumulate
//   q    out  XOR of every din accepted since the last clr or rst
// ---------------------------------------------------------------------------
module parity_accum (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic din,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else if (clr) begin
      q <= 1'b0;
    end else if (en) begin
      q <= q ^ din;
    end
  end

endmodule : parity_accum

// File: rtl/serial_parity_checker.sv
// ---------------------------------------------------------------------------
// serial_parity_checker
//
// Purpose:
//   Receive side of the serial parity link. It deserialises frames made of
//   a start bit, DATA_W data bits (LSB first), a parity bit and a stop bit.
//   It recomputes the parity, checks the stop bit, and hands each word to
//   the downstream consumer.
//
// Parameters:
//   DATA_W      data bits per frame (>= 2)
//   ODD_PARITY  0: even parity (XOR of data and parity is 0)
//               1: odd parity  (XOR of data and parity is 1)
//
// Ports:
//   clk         in   clock; all state changes on the rising edge
//   rst         in   asynchronous reset, active-high
//   rx_en       in   sample strobe; rx_bit is consumed only when rx_en = 1
//   rx_bit      in   serial line, idles at 1
//   data_out    out  last received word
//   data_valid  out  one-cycle pulse: a frame has completed
//   parity_err  out  parity mismatch for the word in data_out
//   frame_err   out  stop bit sampled as 0 for the word in data_out
//   busy        out  high whenever the FSM is not IDLE
//
// Output handshake:
//   The interface is valid-only, with no ready. data_valid is high for
//   exactly one cycle per frame. data_out, parity_err and frame_err change
//   only in that same cycle, and they hold until the next frame completes.
//   The consumer must capture the word on the data_valid cycle.
//
// Timing:
//   A frame takes DATA_W+3 enabled samples. data_valid is high in the
//   cycle after the edge that samples the stop bit. On cycles with
//   rx_en = 0 every register holds, and data_valid reads 0.
//
// Error handling:
//   A bad stop bit still delivers the word, with frame_err set. The FSM then
//   returns to IDLE with no resynchronisation search. The next enabled sample
//   is treated as a possible start bit, so frames may arrive back-to-back.
// ---------------------------------------------------------------------------
module serial_parity_checker
  import serial_parity_checker_pkg::*;
#(
  parameter int DATA_W     = 3,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_en,
  input  logic              rx_bit,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  // The counter indexes data bits 0 .. DATA_W-1 and never passes DATA_W-1.
  localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] sh;
  logic [CNT_W-1:0]  cnt;
  logic              acc;
  logic              perr_q;
  logic              last_data;

  // Per-state sample strobes. Each one already includes rx_en.
  logic              start_smp;
  logic              data_smp;
  logic              parity_smp;
  logic              stop_smp;

  assign last_data = (cnt == CNT_LAST);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (rx_en) begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  //   This is evaluated as if the current cycle were an enabled sample. The
  //   register above ignores the result when rx_en = 0.
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rx_bit == START_LVL) state_nxt = DATA;
      DATA:    if (last_data)           state_nxt = PARITY;
      PARITY:                           state_nxt = STOP;
      STOP:                             state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: output / strobe decode
  // -------------------------------------------------------------------------
  always_comb begin
    start_smp  = 1'b0;
    data_smp   = 1'b0;
    parity_smp = 1'b0;
    stop_smp   = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE:    start_smp  = rx_en & (rx_bit == START_LVL);
      DATA:    data_smp   = rx_en;
      PARITY:  parity_smp = rx_en;
      STOP:    stop_smp   = rx_en;
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Deserialiser and data bit counter.
  //   Data arrives LSB first and enters at the top of the register. After
  //   DATA_W shifts, bit 0 of the word sits at sh[0].
  //   On the last data bit the counter wraps to 0 instead of incrementing.
  //   This keeps it within DATA_W-1 even when DATA_W is a power of two.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh  <= '0;
      cnt <= '0;
    end else if (start_smp) begin
      cnt <= '0;
    end else if (data_smp) begin
      sh  <= {rx_bit, sh[DATA_W-1:1]};
      cnt <= last_data ? '0 : cnt + CNT_W'(1);
    end
  end

  // Running XOR of the data bits. It is cleared by the start bit.
  parity_accum u_parity_accum (
    .clk (clk),
    .rst (rst),
    .clr (start_smp),
    .en  (data_smp),
    .din (rx_bit),
    .q   (acc)
  );

  // The parity verdict is held until the stop bit, so that all three
  // outputs can update in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perr_q <= 1'b0;
    end else if (parity_smp) begin
      perr_q <= acc ^ rx_bit ^ ODD_PARITY;
    end
  end

  // -------------------------------------------------------------------------
  // Output registers. These update only on the stop-bit sample.
  // data_valid follows stop_smp, so it drops on any disabled cycle.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= stop_smp;
      if (stop_smp) begin
        data_out   <= sh;
        parity_err <= perr_q;
        frame_err  <= (rx_bit != STOP_LVL);
      end
    end
  end

endmodule : serial_parity_checker
